// File: rtl/icache_direct_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_direct_pkg;
  localparam int          InstBus          = 32;
  localparam int          ICacheIndexWidth = 7;
  localparam int          ICacheAddrWidth  = 17;
  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam logic        Enable           = 1'b1;
  localparam logic [31:0] CntMax           = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;
endpackage

// File: rtl/icache_direct_if.sv
// Fetch-stage <-> instruction cache bus: lookup, fill, flush and status.
interface icache_direct_if
  import icache_direct_pkg::*;
#(
  parameter int ADDR_WIDTH = ICacheAddrWidth
);
  logic                  read_i;
  logic [ADDR_WIDTH-1:0] read_addr_i;
  logic                  write_i;
  logic [ADDR_WIDTH-1:0] write_addr_i;
  logic [InstBus-1:0]    write_inst_i;
  logic                  flush_i;
  logic                  read_hit_o;
  logic [InstBus-1:0]    read_inst_o;
  logic                  busy_o;
  logic [31:0]           hit_cnt_o;
  logic [31:0]           miss_cnt_o;

  modport master (
    output read_i, read_addr_i, write_i, write_addr_i, write_inst_i, flush_i,
    input  read_hit_o, read_inst_o, busy_o, hit_cnt_o, miss_cnt_o
  );

  modport slave (
    input  read_i, read_addr_i, write_i, write_addr_i, write_inst_i, flush_i,
    output read_hit_o, read_inst_o, busy_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/icache_direct_flush_ctrl.sv
// Invalidate-all sequencer: sweeps every line index once, one clear per cycle.
module icache_flush_ctrl
  import icache_direct_pkg::*;
#(
  parameter int INDEX_WIDTH = ICacheIndexWidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  output logic                   o_busy,
  output logic                   o_clr_en,
  output logic [INDEX_WIDTH-1:0] o_clr_idx
);
  localparam logic [INDEX_WIDTH-1:0] PtrLast = '1;

  flush_state_e           r_state;
  flush_state_e           w_state_nxt;
  logic [INDEX_WIDTH-1:0] r_ptr;
  logic [INDEX_WIDTH-1:0] w_ptr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    o_busy      = 1'b0;
    o_clr_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_flush) begin
          w_state_nxt = ST_FLUSH;
          w_ptr_nxt   = '0;
        end
      end
      ST_FLUSH: begin
        o_busy   = 1'b1;
        o_clr_en = Enable;
        // A new request mid-sweep restarts from line 0 rather than finishing early.
        if (i_flush) begin
          w_ptr_nxt = '0;
        end else if (r_ptr == PtrLast) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign o_clr_idx = r_ptr;
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped one-word-per-line instruction cache with same-cycle fill bypass,
// sequenced invalidate-all and saturating hit/miss counters.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_WIDTH = ICacheIndexWidth,
  parameter int ADDR_WIDTH  = ICacheAddrWidth
) (
  input  logic           clk,
  input  logic           rst,
  icache_direct_if.slave bus
);
  localparam int TagW  = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int Lines = 1 << INDEX_WIDTH;

  logic [Lines-1:0]   r_valid;
  logic [TagW-1:0]    r_tag  [Lines];
  logic [InstBus-1:0] r_data [Lines];
  logic [31:0]        r_hit_cnt;
  logic [31:0]        r_miss_cnt;

  logic [INDEX_WIDTH-1:0] w_rd_idx;
  logic [TagW-1:0]        w_rd_tag;
  logic [INDEX_WIDTH-1:0] w_wr_idx;
  logic [TagW-1:0]        w_wr_tag;
  logic                   w_busy;
  logic                   w_clr_en;
  logic [INDEX_WIDTH-1:0] w_clr_idx;
  logic                   w_idle;
  logic                   w_fill;
  logic                   w_bypass;
  logic                   w_lookup;
  logic                   w_hit;
  logic                   w_unused_lsbs;

  assign w_rd_idx      = bus.read_addr_i[INDEX_WIDTH+1:2];
  assign w_rd_tag      = bus.read_addr_i[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign w_wr_idx      = bus.write_addr_i[INDEX_WIDTH+1:2];
  assign w_wr_tag      = bus.write_addr_i[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign w_unused_lsbs = ^{bus.read_addr_i[1:0], bus.write_addr_i[1:0]};

  icache_flush_ctrl #(
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_flush_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (bus.flush_i),
    .o_busy    (w_busy),
    .o_clr_en  (w_clr_en),
    .o_clr_idx (w_clr_idx)
  );

  // A flush request in the same cycle as a fill wins; the fill is discarded.
  assign w_idle   = ~w_busy;
  assign w_fill   = bus.write_i & w_idle & ~bus.flush_i;
  assign w_bypass = bus.read_i & bus.write_i & w_idle &
                    (bus.read_addr_i[ADDR_WIDTH-1:2] == bus.write_addr_i[ADDR_WIDTH-1:2]);
  assign w_lookup = bus.read_i & w_idle & r_valid[w_rd_idx] & (r_tag[w_rd_idx] == w_rd_tag);
  assign w_hit    = w_bypass | w_lookup;

  assign bus.read_hit_o  = w_hit;
  assign bus.read_inst_o = w_bypass ? bus.write_inst_i :
                           w_lookup ? r_data[w_rd_idx] : ZeroWord;
  assign bus.busy_o      = w_busy;
  assign bus.hit_cnt_o   = r_hit_cnt;
  assign bus.miss_cnt_o  = r_miss_cnt;

  // Clears and fills never coincide: clears only happen while busy, fills only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_clr_en) begin
      r_valid[w_clr_idx] <= 1'b0;
    end else if (w_fill) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= bus.write_inst_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (bus.read_i) begin
      if (w_hit) begin
        if (r_hit_cnt != CntMax) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != CntMax) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Randomized and directed bench for icache_direct against a word-address line model.
module tb_icache_direct;
  logic clk = 1'b0;
  logic rst = 1'b1;

  icache_direct_if #(.ADDR_WIDTH(17)) bus ();

  icache_direct dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each line remembers the full word address it holds (-1 = empty).
  int          m_line [128];
  logic [31:0] m_data [128];
  int          m_busy_left;
  logic [31:0] m_hit;
  logic [31:0] m_miss;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_line[i] = -1;
    m_busy_left = 0;
    m_hit  = 32'd0;
    m_miss = 32'd0;
  endtask

  task automatic step(input logic rd, input logic [16:0] ra, input logic wr,
                      input logic [16:0] wa, input logic [31:0] wd, input logic fl);
    logic        exp_hit;
    logic [31:0] exp_inst;
    int          ridx, widx;
    @(negedge clk);
    bus.read_i       = rd;
    bus.read_addr_i  = ra;
    bus.write_i      = wr;
    bus.write_addr_i = wa;
    bus.write_inst_i = wd;
    bus.flush_i      = fl;
    #2;
    ridx = int'(ra[8:2]);
    widx = int'(wa[8:2]);
    exp_hit  = 1'b0;
    exp_inst = 32'd0;
    if (rd && m_busy_left == 0) begin
      if (wr && (ra >> 2) == (wa >> 2)) begin
        exp_hit  = 1'b1;
        exp_inst = wd;
      end else if (m_line[ridx] == int'(ra >> 2)) begin
        exp_hit  = 1'b1;
        exp_inst = m_data[ridx];
      end
    end
    check_val("read_hit", {31'd0, bus.read_hit_o}, {31'd0, exp_hit});
    check_val("read_inst", bus.read_inst_o, exp_inst);
    check_val("busy", {31'd0, bus.busy_o}, {31'd0, m_busy_left > 0});
    if (rd) begin
      if (exp_hit) begin
        if (m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 1;
      end else begin
        if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
      end
    end
    @(posedge clk);
    if (m_busy_left > 0) begin
      m_busy_left = fl ? 128 : m_busy_left - 1;
    end else if (fl) begin
      m_busy_left = 128;
      for (int i = 0; i < 128; i++) m_line[i] = -1;
    end else if (wr) begin
      m_line[widx] = int'(wa >> 2);
      m_data[widx] = wd;
    end
    #1;
    check_val("hit_cnt", bus.hit_cnt_o, m_hit);
    check_val("miss_cnt", bus.miss_cnt_o, m_miss);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 17'h0, 1'b0, 17'h0, 32'h0, 1'b0);
  endtask

  task automatic read_a(input logic [16:0] a);
    step(1'b1, a, 1'b0, 17'h0, 32'h0, 1'b0);
  endtask

  task automatic write_a(input logic [16:0] a, input logic [31:0] d);
    step(1'b0, 17'h0, 1'b1, a, d, 1'b0);
  endtask

  task automatic flush_pulse();
    step(1'b0, 17'h0, 1'b0, 17'h0, 32'h0, 1'b1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    bus.flush_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_val("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check_val("rst_hit_cnt", bus.hit_cnt_o, 32'd0);
    check_val("rst_miss_cnt", bus.miss_cnt_o, 32'd0);
    check_val("rst_read_hit", {31'd0, bus.read_hit_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [16:0] rand_addr();
    logic [7:0] t;
    logic [6:0] ix;
    logic [1:0] lo;
    t  = 8'($urandom_range(0, 3));
    ix = 7'($urandom_range(0, 7));
    lo = 2'($urandom_range(0, 3));
    return {t, ix, lo};
  endfunction

  initial begin
    logic        rd, wr, fl;
    logic [16:0] ra, wa;
    bus.read_i       = 1'b0;
    bus.read_addr_i  = '0;
    bus.write_i      = 1'b0;
    bus.write_addr_i = '0;
    bus.write_inst_i = '0;
    bus.flush_i      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("por_busy", {31'd0, bus.busy_o}, 32'd0);
    check_val("por_hit_cnt", bus.hit_cnt_o, 32'd0);
    check_val("por_miss_cnt", bus.miss_cnt_o, 32'd0);
    rst = 1'b0;

    read_a(17'h00010);
    write_a(17'h00010, 32'h0050_0093);
    read_a(17'h00010);
    read_a(17'h00012);
    write_a(17'h00210, 32'h0010_0113);
    read_a(17'h00010);
    read_a(17'h00210);
    step(1'b1, 17'h00044, 1'b1, 17'h00044, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 17'h00244, 1'b1, 17'h00044, 32'h1234_5678, 1'b0);
    read_a(17'h00044);

    write_a(17'h00100, 32'h1111_1111);
    write_a(17'h00104, 32'h2222_2222);
    write_a(17'h00108, 32'h3333_3333);
    step(1'b1, 17'h00104, 1'b1, 17'h0010C, 32'h4444_4444, 1'b1);
    for (int i = 0; i < 128; i++)
      step(1'b1, 17'h00100, 1'b1, 17'h0010C, 32'h5555_5555, 1'b0);
    read_a(17'h00100);
    read_a(17'h00104);
    read_a(17'h00108);
    read_a(17'h0010C);

    write_a(17'h00100, 32'h6666_6666);
    flush_pulse();
    idle(59);
    flush_pulse();
    for (int i = 0; i < 130; i++) read_a(17'h00100);

    write_a(17'h00104, 32'h7777_7777);
    flush_pulse();
    idle(29);
    async_reset();
    read_a(17'h00104);
    write_a(17'h00104, 32'h8888_8888);
    read_a(17'h00104);

    for (int i = 0; i < 2000; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 299) == 0);
      if (fl) wr = 1'b0;
      ra = rand_addr();
      wa = ($urandom_range(0, 3) == 0) ? ra : rand_addr();
      step(rd, ra, wr, wa, $urandom, fl);
    end
    idle(130);

    write_a(17'h00020, 32'hCAFE_F00D);
    @(negedge clk);
    force dut.r_hit_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_hit_cnt;
    m_hit = 32'hFFFF_FFFE;
    read_a(17'h00020);
    read_a(17'h00020);
    read_a(17'h00020);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
